iteration_end_reporter: RTL and testbench



---
 rtl/iteration_end_reporter.sv | 162 ++++++++++++++++
 tb/tb_iteration_end_reporter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iteration_end_reporter.sv
// iteration_end_reporter: per-core drain tracker and iteration-end handshake.
// Raises this core's end flag after a quiet drain, then waits for the global ack.
module iteration_end_reporter #(
  parameter int OUTSTANDING_WIDTH = 16,
  parameter int ITER_WIDTH = 8,
  parameter int QUIET_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] max_iteration,
  input  logic                  issue_valid,
  input  logic                  retire_valid,
  input  logic                  src_empty,
  input  logic                  global_iteration_end,
  input  logic                  global_iteration_end_valid,
  output logic                  iteration_end,
  output logic                  iteration_end_valid,
  output logic [ITER_WIDTH-1:0] iteration_id,
  output logic                  iteration_start,
  output logic                  busy,
  output logic                  done,
  output logic                  err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_QUIET,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] QUIET_LIMIT = 8'(QUIET_CYCLES);

  state_t                       state;
  state_t                       state_n;
  logic [OUTSTANDING_WIDTH-1:0] outstanding;
  logic [OUTSTANDING_WIDTH-1:0] outstanding_n;
  logic [7:0]                   quiet_cnt;
  logic [7:0]                   quiet_n;
  logic [ITER_WIDTH-1:0]        max_q;
  logic [ITER_WIDTH-1:0]        max_n;
  logic [ITER_WIDTH-1:0]        id_n;
  logic [ITER_WIDTH-1:0]        id_inc;
  logic                         start_n;
  logic                         err_n;
  logic                         active;
  logic                         drained;
  logic                         ack;
  logic                         inc;
  logic                         dec;
  logic                         run_n;

  assign active  = (state == S_RUN) || (state == S_QUIET)
                || (state == S_WAIT);
  assign drained = (outstanding == '0) && src_empty && !issue_valid;
  assign ack     = global_iteration_end_valid && global_iteration_end;
  assign id_inc  = iteration_id + ITER_WIDTH'(1);
  assign inc     = active && issue_valid && !retire_valid;
  assign dec     = active && retire_valid && !issue_valid;
  assign run_n   = (state_n == S_RUN) || (state_n == S_QUIET)
                || (state_n == S_WAIT);

  // In-flight counter: saturates at both ends and flags the attempt.
  always_comb begin
    outstanding_n = outstanding;
    err_n         = err_count;
    unique case (1'b1)
      inc: begin
        if (&outstanding) err_n = 1'b1;
        else outstanding_n = outstanding + 1'b1;
      end
      dec: begin
        if (outstanding == '0) err_n = 1'b1;
        else outstanding_n = outstanding - 1'b1;
      end
      default: ;
    endcase
  end

  // Iteration FSM: run, quiet-drain window, wait for the global ack.
  always_comb begin
    state_n = state;
    quiet_n = quiet_cnt;
    max_n   = max_q;
    id_n    = iteration_id;
    start_n = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          max_n   = max_iteration;
          id_n    = '0;
          quiet_n = '0;
          start_n = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (drained) begin
          quiet_n = 8'd1;
          state_n = S_QUIET;
        end
      end
      S_QUIET: begin
        if (!drained) begin
          quiet_n = '0;
          state_n = S_RUN;
        end else if (quiet_cnt == QUIET_LIMIT) begin
          quiet_n = '0;
          state_n = S_WAIT;
        end else begin
          quiet_n = quiet_cnt + 8'd1;
        end
      end
      S_WAIT: begin
        if (issue_valid || !src_empty) begin
          state_n = S_RUN;
        end else if (ack) begin
          id_n = id_inc;
          if ((max_q != '0) && (id_inc == max_q)) begin
            state_n = S_DONE;
          end else begin
            start_n = 1'b1;
            state_n = S_RUN;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      outstanding         <= '0;
      quiet_cnt           <= '0;
      max_q               <= '0;
      iteration_id        <= '0;
      iteration_start     <= 1'b0;
      iteration_end       <= 1'b0;
      iteration_end_valid <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      err_count           <= 1'b0;
    end else begin
      state               <= state_n;
      outstanding         <= outstanding_n;
      quiet_cnt           <= quiet_n;
      max_q               <= max_n;
      iteration_id        <= id_n;
      iteration_start     <= start_n;
      iteration_end       <= (state_n == S_WAIT);
      iteration_end_valid <= run_n;
      busy                <= run_n;
      done                <= (state_n == S_DONE);
      err_count           <= err_n;
    end
  end

endmodule

// File: tb/tb_iteration_end_reporter.sv
// tb_iteration_end_reporter: directed plus random stimulus against a
// drain-streak reference model; every output compared each cycle.
module tb_iteration_end_reporter;

  localparam int OW = 4;
  localparam int IW = 8;
  localparam int QC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] max_iteration;
  logic          issue_valid;
  logic          retire_valid;
  logic          src_empty;
  logic          gie;
  logic          giev;
  logic          iteration_end;
  logic          iteration_end_valid;
  logic [IW-1:0] iteration_id;
  logic          iteration_start;
  logic          busy;
  logic          done;
  logic          err_count;

  iteration_end_reporter #(
    .OUTSTANDING_WIDTH(OW),
    .ITER_WIDTH(IW),
    .QUIET_CYCLES(QC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .max_iteration(max_iteration),
    .issue_valid(issue_valid),
    .retire_valid(retire_valid),
    .src_empty(src_empty),
    .global_iteration_end(gie),
    .global_iteration_end_valid(giev),
    .iteration_end(iteration_end),
    .iteration_end_valid(iteration_end_valid),
    .iteration_id(iteration_id),
    .iteration_start(iteration_start),
    .busy(busy),
    .done(done),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: work in flight, consecutive drained cycles,
  // and whether this core is running, reporting or finished.
  bit m_active;
  bit m_done;
  bit m_reported;
  bit m_pulse;
  bit m_err;
  int m_out;
  int m_streak;
  int m_id;
  int m_max;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit drained;
    bit ack;
    if (rst) begin
      m_active = 0; m_done = 0; m_reported = 0; m_pulse = 0;
      m_err = 0; m_out = 0; m_streak = 0; m_id = 0; m_max = 0;
      return;
    end
    m_pulse = 0;
    if (!m_active) begin
      if (start) begin
        m_max = max_iteration; m_id = 0; m_active = 1; m_done = 0;
        m_reported = 0; m_streak = 0; m_pulse = 1;
      end
      return;
    end
    drained = (m_out == 0) && src_empty && !issue_valid;
    ack = giev && gie;
    if (issue_valid && !retire_valid) begin
      if (m_out == (1 << OW) - 1) m_err = 1;
      else m_out++;
    end else if (retire_valid && !issue_valid) begin
      if (m_out == 0) m_err = 1;
      else m_out--;
    end
    if (m_reported) begin
      if (issue_valid || !src_empty) begin
        m_reported = 0; m_streak = 0;
      end else if (ack) begin
        m_reported = 0; m_streak = 0;
        m_id = (m_id + 1) % (1 << IW);
        if (m_max != 0 && m_id == m_max) begin
          m_active = 0; m_done = 1;
        end else begin
          m_pulse = 1;
        end
      end
    end else if (drained) begin
      m_streak++;
      if (m_streak == QC + 1) m_reported = 1;
    end else begin
      m_streak = 0;
    end
  endtask

  task automatic compare_all();
    check("iteration_end", iteration_end, m_reported);
    check("iteration_end_valid", iteration_end_valid, m_active);
    check("busy", busy, m_active);
    check("done", done, m_done);
    check("iteration_start", iteration_start, m_pulse);
    check("err_count", err_count, m_err);
    check("iteration_id", iteration_id, m_id[IW-1:0]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    start = 0; issue_valid = 0; retire_valid = 0;
    src_empty = 1; gie = 0; giev = 0;
  endtask

  task automatic drain_to_wait();
    idle_inputs();
    for (int i = 0; i < 64 && !m_reported; i++) begin
      retire_valid = (m_out > 0);
      cycle();
    end
    retire_valid = 0;
    check("drain_reported", iteration_end, 1'b1);
  endtask

  task automatic ack_cycle();
    gie = 1; giev = 1;
    cycle();
    gie = 0; giev = 0;
  endtask

  task automatic do_start(int mx);
    idle_inputs();
    start = 1; max_iteration = IW'(mx);
    cycle();
    start = 0;
  endtask

  task automatic expect_end_after_quiet(string tag);
    repeat (QC) cycle();
    check({tag, "_early"}, iteration_end, 1'b0);
    cycle();
    check({tag, "_end"}, iteration_end, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_id;
    idle_inputs();
    max_iteration = '0;
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    cycle();

    // Basic three-iteration run
    do_start(3);
    check("t1_start_pulse", iteration_start, 1'b1);
    check("t1_id0", iteration_id, 0);
    expect_end_after_quiet("t1");
    ack_cycle();
    check("t1_id1", iteration_id, 1);
    check("t1_pulse1", iteration_start, 1'b1);
    drain_to_wait();
    ack_cycle();
    drain_to_wait();
    ack_cycle();
    check("t1_done", done, 1'b1);
    check("t1_busy", busy, 1'b0);
    check("t1_id3", iteration_id, 3);
    repeat (3) cycle();

    // Outstanding work holds off the report
    do_start(0);
    issue_valid = 1;
    repeat (3) cycle();
    issue_valid = 0; retire_valid = 1;
    cycle();
    issue_valid = 1;
    cycle();
    issue_valid = 0;
    repeat (2) cycle();
    retire_valid = 0;
    expect_end_after_quiet("t2");
    check("t2_err", err_count, 1'b0);
    ack_cycle();

    // Issue pulse on quiet cycle 2 restarts the window
    repeat (2) cycle();
    issue_valid = 1;
    cycle();
    issue_valid = 0; retire_valid = 1;
    cycle();
    retire_valid = 0;
    expect_end_after_quiet("t3");

    // Withdrawal beats a same-cycle ack
    saved_id = m_id;
    issue_valid = 1; gie = 1; giev = 1;
    cycle();
    idle_inputs();
    check("t4_end_drop", iteration_end, 1'b0);
    check("t4_id_hold", iteration_id, saved_id);
    check("t4_no_start", iteration_start, 1'b0);
    drain_to_wait();

    // Global valid without end does not advance
    giev = 1; gie = 0;
    repeat (10) cycle();
    check("t5_end_held", iteration_end, 1'b1);
    check("t5_id_hold", iteration_id, saved_id);
    gie = 1;
    cycle();
    idle_inputs();
    check("t5_advance", iteration_id, saved_id + 1);

    // Overflow, reset in WAIT_GLOBAL, underflow
    issue_valid = 1;
    repeat ((1 << OW) + 1) cycle();
    issue_valid = 0;
    check("t6_overflow", err_count, 1'b1);
    drain_to_wait();
    rst = 1;
    cycle();
    rst = 0;
    check("t6_rst_end", iteration_end, 1'b0);
    check("t6_rst_valid", iteration_end_valid, 1'b0);
    check("t6_rst_err", err_count, 1'b0);
    check("t6_rst_id", iteration_id, 0);
    do_start(0);
    retire_valid = 1;
    cycle();
    retire_valid = 0;
    check("t6_underflow", err_count, 1'b1);

    // Unbounded run wraps the iteration id
    for (int k = 0; k < 256; k++) begin
      drain_to_wait();
      ack_cycle();
    end
    check("t6_wrap_id", iteration_id, 0);
    check("t6_wrap_done", done, 1'b0);
    check("t6_wrap_busy", busy, 1'b1);

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      rst           = ($urandom_range(127) == 0);
      start         = ($urandom_range(15) == 0);
      max_iteration = IW'($urandom_range(4));
      issue_valid   = ($urandom_range(3) == 0);
      retire_valid  = ($urandom_range(2) == 0);
      src_empty     = ($urandom_range(7) != 0);
      giev          = $urandom_range(1) == 1;
      gie           = $urandom_range(1) == 1;
      cycle();
    end
    rst = 0;
    idle_inputs();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
